// File: rtl/reference_buffer_pkg.sv
// Shared types and helpers for the burst-read reference buffer.
package reference_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST,
        ST_DRAIN
    } state_t;

    localparam int SKID_DEPTH = 2;

    // Two's-complement negate of a width-bit value held sign-extended in 32 bits;
    // the most negative code saturates to the most positive one.
    function automatic logic signed [31:0] sat_neg(input logic signed [31:0] v,
                                                   input int unsigned width);
        logic signed [31:0] min_v;
        min_v = -(32'sd1 <<< (width - 1));
        if (v == min_v) begin
            return -min_v - 32'sd1;
        end
        return -v;
    endfunction

endpackage

// File: rtl/reference_buffer_ram.sv
// Simple dual-port RAM: one write port, one registered read port, read-before-write.
module reference_buffer_ram #(
    parameter int WIDTH     = 24,
    parameter int DEPTH     = 64,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 wr_en_i,
    input  logic [ADDR_BITS-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]     wr_data_i,
    input  logic                 rd_en_i,
    input  logic [ADDR_BITS-1:0] rd_addr_i,
    output logic [WIDTH-1:0]     rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/reference_buffer_burst.sv
// Circular I/Q reference store: sequential fill, burst reads with wrap and AXI-style backpressure.
// Optional: define REFERENCE_BUFFER_CONJ_EN to add conj_en (saturating q negation per burst).
module reference_buffer_burst
    import reference_buffer_pkg::*;
#(
    parameter int I_BITS        = 12,
    parameter int Q_BITS        = 12,
    parameter int BUFFER_LENGTH = 64,
    parameter int BUFFER_BITS   = $clog2(BUFFER_LENGTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   m_axis_wr_tvalid,
    output logic                   m_axis_wr_tready,
    input  logic [I_BITS-1:0]      m_axis_wr_i,
    input  logic [Q_BITS-1:0]      m_axis_wr_q,
    input  logic                   m_axis_index_tvalid,
    output logic                   m_axis_index_tready,
    input  logic [BUFFER_BITS-1:0] m_axis_index_tdata,
    input  logic [BUFFER_BITS:0]   m_axis_len_tdata,
`ifdef REFERENCE_BUFFER_CONJ_EN
    input  logic                   conj_en,
`endif
    input  logic                   m_axis_tready,
    output logic                   s_axis_data_tvalid,
    output logic                   s_axis_data_tlast,
    output logic [I_BITS-1:0]      i,
    output logic [Q_BITS-1:0]      q,
    output logic [BUFFER_BITS:0]   fill_count,
    output logic                   err_index
);

    localparam int DATA_W  = I_BITS + Q_BITS;
    localparam int ENTRY_W = DATA_W + 1;
    localparam logic [BUFFER_BITS-1:0] LAST_ADDR = BUFFER_BITS'(BUFFER_LENGTH - 1);
    localparam logic [BUFFER_BITS:0]   FULL      = (BUFFER_BITS + 1)'(BUFFER_LENGTH);

    function automatic logic [BUFFER_BITS-1:0] wrap_inc(input logic [BUFFER_BITS-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    logic                   ready_q;
    logic [BUFFER_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [BUFFER_BITS:0]   fill_q, fill_d;
    state_t                 state_q, state_d;
    logic [BUFFER_BITS-1:0] addr_q, addr_d;
    logic [BUFFER_BITS:0]   remain_q, remain_d;
    logic                   err_q, err_d;
    logic                   rd_vld_q, rd_last_q;
    logic [ENTRY_W-1:0]     skid0_q, skid0_d, skid1_q, skid1_d;
    logic [1:0]             cnt_q, cnt_d;
    logic                   conj_q, conj_d;

    logic                   wr_hs, cmd_hs, index_bad, pop, push, can_issue;
    logic                   rd_en, rd_last;
    logic [BUFFER_BITS-1:0] rd_addr;
    logic [BUFFER_BITS:0]   len_eff;
    logic [DATA_W-1:0]      rd_data;
    logic [Q_BITS-1:0]      rd_q_adj;
    logic [ENTRY_W-1:0]     push_entry;
    logic [2:0]             occ;
    logic [1:0]             base;

    assign wr_hs     = m_axis_wr_tvalid && ready_q;
    assign cmd_hs    = m_axis_index_tvalid && m_axis_index_tready;
    assign index_bad = {1'b0, m_axis_index_tdata} >= FULL;
    assign len_eff   = (m_axis_len_tdata == '0) ? (BUFFER_BITS + 1)'(1) : m_axis_len_tdata;

    assign wr_ptr_d = wr_hs ? wrap_inc(wr_ptr_q) : wr_ptr_q;
    assign fill_d   = (wr_hs && fill_q != FULL) ? fill_q + 1'b1 : fill_q;

    reference_buffer_ram #(
        .WIDTH    (DATA_W),
        .DEPTH    (BUFFER_LENGTH),
        .ADDR_BITS(BUFFER_BITS)
    ) u_ram (
        .clk      (clk),
        .wr_en_i  (wr_hs),
        .wr_addr_i(wr_ptr_q),
        .wr_data_i({m_axis_wr_i, m_axis_wr_q}),
        .rd_en_i  (rd_en),
        .rd_addr_i(rd_addr),
        .rd_data_o(rd_data)
    );

    // A new read may issue only if its data is guaranteed a skid slot next cycle.
    assign pop       = (cnt_q != 2'd0) && m_axis_tready;
    assign push      = rd_vld_q;
    assign occ       = {1'b0, cnt_q} + {2'b0, rd_vld_q} - {2'b0, pop};
    assign can_issue = occ < 3'(SKID_DEPTH);

    // The accept cycle issues the first read directly from the command, giving two-cycle latency.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        conj_d   = conj_q;
        err_d    = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = addr_q;
        rd_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_hs) begin
                    if (index_bad) begin
                        err_d = 1'b1;
                    end else begin
                        rd_en    = 1'b1;
                        rd_addr  = m_axis_index_tdata;
                        rd_last  = (len_eff == (BUFFER_BITS + 1)'(1));
                        addr_d   = wrap_inc(m_axis_index_tdata);
                        remain_d = len_eff - 1'b1;
`ifdef REFERENCE_BUFFER_CONJ_EN
                        conj_d   = conj_en;
`endif
                        state_d  = rd_last ? ST_DRAIN : ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                if (can_issue) begin
                    rd_en    = 1'b1;
                    rd_last  = (remain_q == (BUFFER_BITS + 1)'(1));
                    addr_d   = wrap_inc(addr_q);
                    remain_d = remain_q - 1'b1;
                    if (rd_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && skid0_q[ENTRY_W-1]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef REFERENCE_BUFFER_CONJ_EN
    assign rd_q_adj = conj_q ? Q_BITS'(sat_neg(32'($signed(rd_data[Q_BITS-1:0])), Q_BITS))
                             : rd_data[Q_BITS-1:0];
`else
    assign rd_q_adj = rd_data[Q_BITS-1:0];
`endif
    assign push_entry = {rd_last_q, rd_data[DATA_W-1:Q_BITS], rd_q_adj};

    always_comb begin
        skid0_d = skid0_q;
        skid1_d = skid1_q;
        cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop};
        base    = cnt_q - {1'b0, pop};
        if (pop) begin
            skid0_d = skid1_q;
        end
        if (push) begin
            if (base == 2'd0) begin
                skid0_d = push_entry;
            end else begin
                skid1_d = push_entry;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q   <= 1'b0;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            remain_q  <= '0;
            err_q     <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            skid0_q   <= '0;
            skid1_q   <= '0;
            cnt_q     <= '0;
            conj_q    <= 1'b0;
        end else begin
            ready_q   <= 1'b1;
            wr_ptr_q  <= wr_ptr_d;
            fill_q    <= fill_d;
            state_q   <= state_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            err_q     <= err_d;
            rd_vld_q  <= rd_en;
            rd_last_q <= rd_last;
            skid0_q   <= skid0_d;
            skid1_q   <= skid1_d;
            cnt_q     <= cnt_d;
            conj_q    <= conj_d;
        end
    end

    assign m_axis_wr_tready    = ready_q;
    assign m_axis_index_tready = ready_q && (state_q == ST_IDLE);
    assign s_axis_data_tvalid  = (cnt_q != 2'd0);
    assign s_axis_data_tlast   = s_axis_data_tvalid && skid0_q[ENTRY_W-1];
    assign i                   = skid0_q[DATA_W-1:Q_BITS];
    assign q                   = skid0_q[Q_BITS-1:0];
    assign fill_count          = fill_q;
    assign err_index           = err_q;

endmodule

// File: tb/tb_reference_buffer_burst.sv
// Directed bench for reference_buffer_burst: bursts, wrap, backpressure, overflow, bad index, reset.
module tb_reference_buffer_burst;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        wr_tvalid = 1'b0;
    logic        wr_tready;
    logic [11:0] wr_i = '0, wr_q = '0;
    logic        idx_tvalid = 1'b0;
    logic        idx_tready;
    logic [5:0]  idx = '0;
    logic [6:0]  len = '0;
    logic        tready = 1'b0;
    logic        tvalid, tlast, err;
    logic [11:0] out_i, out_q;
    logic [6:0]  fill;
`ifdef REFERENCE_BUFFER_CONJ_EN
    logic        conj = 1'b0;
`endif

    logic        b_idx_tvalid = 1'b0;
    logic [5:0]  b_idx = '0;
    logic        b_wr_tready, b_idx_tready, b_tvalid, b_tlast, b_err;
    logic [11:0] b_i, b_q;
    logic [6:0]  b_fill;

    reference_buffer_burst #(.I_BITS(12), .Q_BITS(12), .BUFFER_LENGTH(64)) u_dut (
        .clk(clk), .rst(rst),
        .m_axis_wr_tvalid(wr_tvalid), .m_axis_wr_tready(wr_tready),
        .m_axis_wr_i(wr_i), .m_axis_wr_q(wr_q),
        .m_axis_index_tvalid(idx_tvalid), .m_axis_index_tready(idx_tready),
        .m_axis_index_tdata(idx), .m_axis_len_tdata(len),
`ifdef REFERENCE_BUFFER_CONJ_EN
        .conj_en(conj),
`endif
        .m_axis_tready(tready),
        .s_axis_data_tvalid(tvalid), .s_axis_data_tlast(tlast),
        .i(out_i), .q(out_q), .fill_count(fill), .err_index(err)
    );

    reference_buffer_burst #(.I_BITS(12), .Q_BITS(12), .BUFFER_LENGTH(48)) u_dut48 (
        .clk(clk), .rst(rst),
        .m_axis_wr_tvalid(1'b0), .m_axis_wr_tready(b_wr_tready),
        .m_axis_wr_i(wr_i), .m_axis_wr_q(wr_q),
        .m_axis_index_tvalid(b_idx_tvalid), .m_axis_index_tready(b_idx_tready),
        .m_axis_index_tdata(b_idx), .m_axis_len_tdata(7'd1),
`ifdef REFERENCE_BUFFER_CONJ_EN
        .conj_en(1'b0),
`endif
        .m_axis_tready(1'b1),
        .s_axis_data_tvalid(b_tvalid), .s_axis_data_tlast(b_tlast),
        .i(b_i), .q(b_q), .fill_count(b_fill), .err_index(b_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int got_i[$], got_q[$], got_last[$];
    int lat;
    int idle_after;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic write_sample(input int vi, input int vq);
        wr_i = vi[11:0];
        wr_q = vq[11:0];
        wr_tvalid = 1'b1;
        tick();
        wr_tvalid = 1'b0;
    endtask

    // Issues one command, then collects the burst; bp alternates tready 1,0,1,0...
    task automatic run_burst(input int start, input int n, input bit bp);
        bit stalled, done, rdy;
        int hi, hq, hl;
        got_i.delete(); got_q.delete(); got_last.delete();
        lat = -1; stalled = 0; done = 0; hi = 0; hq = 0; hl = 0;
        check("cmd_ready", int'(idx_tready), 1);
        idx = start[5:0];
        len = n[6:0];
        idx_tvalid = 1'b1;
        tready = 1'b1;
        tick();
        idx_tvalid = 1'b0;
        wr_tvalid = 1'b0;
        for (int k = 1; k < 200 && !done; k++) begin
            rdy = bp ? (k % 2 == 0) : 1'b1;
            tready = rdy;
            if (stalled) begin
                check("hold_valid", int'(tvalid), 1);
                check("hold_i", $signed(out_i), hi);
                check("hold_q", $signed(out_q), hq);
                check("hold_last", int'(tlast), hl);
                stalled = 0;
            end
            if (tvalid && lat < 0) lat = k;
            if (tvalid && rdy) begin
                got_i.push_back($signed(out_i));
                got_q.push_back($signed(out_q));
                got_last.push_back(int'(tlast));
                $display("rx i=%0d q=%0d last=%0d", $signed(out_i), $signed(out_q), tlast);
                if (tlast) done = 1;
            end else if (tvalid) begin
                stalled = 1;
                hi = $signed(out_i); hq = $signed(out_q); hl = int'(tlast);
            end
            tick();
        end
        if (!done) check("burst_timeout", 0, 1);
        idle_after = int'(idx_tready);
        tready = 1'b1;
    endtask

    task automatic expect_seq(input string tag, input int n, input int first_i, input int wrap_at);
        int e;
        check({tag, "_count"}, got_i.size(), n);
        for (int j = 0; j < n && j < got_i.size(); j++) begin
            e = (first_i + j) % wrap_at;
            check({tag, "_i"}, got_i[j], e);
            check({tag, "_q"}, got_q[j], -e);
            check({tag, "_last"}, got_last[j], (j == n - 1) ? 1 : 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int errs, vals, nvalid;

        // Reset state
        repeat (3) tick();
        check("rst_wr_tready", int'(wr_tready), 0);
        check("rst_idx_tready", int'(idx_tready), 0);
        check("rst_tvalid", int'(tvalid), 0);
        check("rst_tlast", int'(tlast), 0);
        check("rst_fill", int'(fill), 0);
        check("rst_i", int'(out_i), 0);
        check("rst_err", int'(err), 0);
        rst = 1'b0;
        tick();
        check("rel_idx_tready", int'(idx_tready), 1);
        check("rel_wr_tready", int'(wr_tready), 1);

        // Basic burst
        for (int k = 0; k < 8; k++) write_sample(k, -k);
        check("basic_fill", int'(fill), 8);
        run_burst(2, 4, 0);
        check("basic_latency", lat, 2);
        check("basic_idle_after", idle_after, 1);
        check("basic_tvalid_after", int'(tvalid), 0);
        expect_seq("basic", 4, 2, 64);

        // Wrap and backpressure
        do_reset();
        for (int k = 0; k < 64; k++) write_sample(k, -k);
        check("full_fill", int'(fill), 64);
        run_burst(62, 4, 0);
        expect_seq("wrap", 4, 62, 64);
        run_burst(0, 8, 1);
        expect_seq("bp", 8, 0, 64);

        // Overflow, then zero length treated as one
        do_reset();
        for (int k = 0; k < 70; k++) write_sample(k, -k);
        check("ovf_fill", int'(fill), 64);
        run_burst(0, 6, 0);
        expect_seq("ovf", 6, 64, 1000);
        run_burst(3, 0, 0);
        expect_seq("len0", 1, 67, 1000);

        // Read-before-write: address 8 last held 8 from the overflow fill
        do_reset();
        for (int k = 0; k < 8; k++) write_sample(200 + k, -(200 + k));
        wr_i = 12'd300;
        wr_q = 12'(-300);
        wr_tvalid = 1'b1;
        run_burst(8, 1, 0);
        expect_seq("rbw_old", 1, 8, 1000);
        run_burst(8, 1, 0);
        expect_seq("rbw_new", 1, 300, 1000);

        // Bad index on the 48-deep instance
        check("bad_cmd_ready", int'(b_idx_tready), 1);
        b_idx = 6'd50;
        b_idx_tvalid = 1'b1;
        tick();
        b_idx_tvalid = 1'b0;
        check("bad_err_first", int'(b_err), 1);
        errs = 0; vals = 0;
        for (int k = 0; k < 6; k++) begin
            errs += int'(b_err);
            vals += int'(b_tvalid);
            tick();
        end
        check("bad_err_pulses", errs, 1);
        check("bad_no_output", vals, 0);
        check("bad_idle", int'(b_idx_tready), 1);

        // Reset mid-burst on the 3rd output sample
        do_reset();
        for (int k = 0; k < 8; k++) write_sample(k, -k);
        idx = 6'd0; len = 7'd8; idx_tvalid = 1'b1; tready = 1'b1;
        tick();
        idx_tvalid = 1'b0;
        nvalid = 0;
        for (int k = 0; k < 20 && nvalid < 3; k++) begin
            if (tvalid) nvalid++;
            if (nvalid < 3) tick();
        end
        check("mid_third_i", $signed(out_i), 2);
        rst = 1'b1;
        tick();
        check("mid_tvalid", int'(tvalid), 0);
        check("mid_fill", int'(fill), 0);
        check("mid_i", int'(out_i), 0);
        check("mid_idx_tready", int'(idx_tready), 0);
        rst = 1'b0;
        tick();
        check("mid_rel_idx_tready", int'(idx_tready), 1);

        // q pass-through (and saturating conjugate when built with it)
        do_reset();
        write_sample(1, -2048);
        write_sample(2, 5);
        write_sample(3, 0);
        run_burst(0, 3, 0);
        check("pass_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("pass_q0", got_q[0], -2048);
            check("pass_q1", got_q[1], 5);
            check("pass_q2", got_q[2], 0);
        end
`ifdef REFERENCE_BUFFER_CONJ_EN
        conj = 1'b1;
        run_burst(0, 3, 0);
        conj = 1'b0;
        check("conj_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("conj_q0", got_q[0], 2047);
            check("conj_q1", got_q[1], -5);
            check("conj_q2", got_q[2], 0);
            check("conj_i0", got_i[0], 1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
